// File: rtl/axi_bist_mem_responder_pkg.sv
// ============================================================================
// Module  : axi_bist_mem_responder_pkg
// Brief   : Shared AXI encodings, beat-shift helper and FSM state types.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_bist_mem_responder_pkg;

    localparam logic [1:0] c_BURST_INCR = 2'b01;
    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Byte-address bits below the word index for a given data width.
    function automatic int beat_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RIDLE  = 2'd0,
        RFETCH = 2'd1,
        RDATA  = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_bist_mem_dpram.sv
// ============================================================================
// Module  : axi_bist_mem_dpram
// Brief   : Dual-port word array, byte-enabled write, registered read-first read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_bist_mem_dpram
    import axi_bist_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic                    i_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write and read share one process so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/axi_bist_mem_responder.sv
// ============================================================================
// Module  : axi_bist_mem_responder
// Brief   : AXI4 INCR-burst slave memory model with independent write/read engines.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_bist_mem_responder
    import axi_bist_mem_responder_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]                  axi_awid,
    input  logic [7:0]                  axi_awlen,
    input  logic [2:0]                  axi_awsize,
    input  logic [1:0]                  axi_awburst,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_wlast,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [7:0]                  axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]                  axi_arid,
    input  logic [7:0]                  axi_arlen,
    input  logic [2:0]                  axi_arsize,
    input  logic [1:0]                  axi_arburst,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [7:0]                  axi_rid,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready
);

    localparam int c_S = beat_shift(AXI_DATA_WIDTH);

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t                 r_wstate;
    wr_state_t                 w_wstate_nxt;
    logic [7:0]                r_wid;
    logic [7:0]                r_wlen;
    logic [7:0]                r_wcnt;
    logic [MEM_ADDR_WIDTH-1:0] r_widx;
    logic                      r_werr;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_wbeat_last;
    logic                      w_mem_we;

    assign w_aw_hs      = axi_awvalid & axi_awready;
    assign w_w_hs       = axi_wvalid & axi_wready;
    assign w_wbeat_last = (r_wcnt == r_wlen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= WIDLE;
            r_wid    <= 8'd0;
            r_wlen   <= 8'd0;
            r_wcnt   <= 8'd0;
            r_widx   <= '0;
            r_werr   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_wid  <= axi_awid;
                r_wlen <= axi_awlen;
                r_widx <= axi_awaddr[MEM_ADDR_WIDTH+c_S-1 -: MEM_ADDR_WIDTH];
                r_werr <= (axi_awburst != c_BURST_INCR);
                r_wcnt <= 8'd0;
            end else if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt + 8'd1;
                // A misplaced WLAST poisons the response but not the beat count.
                if (axi_wlast != w_wbeat_last) begin
                    r_werr <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        axi_awready  = 1'b0;
        axi_wready   = 1'b0;
        axi_bvalid   = 1'b0;
        axi_bresp    = c_RESP_OKAY;
        w_mem_we     = 1'b0;
        case (r_wstate)
            WIDLE: begin
                axi_awready = 1'b1;
                if (axi_awvalid) begin
                    w_wstate_nxt = WDATA;
                end
            end
            WDATA: begin
                axi_wready = 1'b1;
                w_mem_we   = axi_wvalid & ~r_werr;
                if (axi_wvalid && w_wbeat_last) begin
                    w_wstate_nxt = WRESP;
                end
            end
            WRESP: begin
                axi_bvalid = 1'b1;
                axi_bresp  = r_werr ? c_RESP_SLVERR : c_RESP_OKAY;
                if (axi_bready) begin
                    w_wstate_nxt = WIDLE;
                end
            end
            default: w_wstate_nxt = WIDLE;
        endcase
    end

    assign axi_bid = r_wid;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t                 r_rstate;
    rd_state_t                 w_rstate_nxt;
    logic [7:0]                r_rid;
    logic [7:0]                r_rlen;
    logic [7:0]                r_rcnt;
    logic [MEM_ADDR_WIDTH-1:0] r_ridx;
    logic                      r_rerr;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_rbeat_last;
    logic                      w_mem_re;
    logic [AXI_DATA_WIDTH-1:0] w_mem_q;

    assign w_ar_hs      = axi_arvalid & axi_arready;
    assign w_r_hs       = axi_rvalid & axi_rready;
    assign w_rbeat_last = (r_rcnt == r_rlen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= RIDLE;
            r_rid    <= 8'd0;
            r_rlen   <= 8'd0;
            r_rcnt   <= 8'd0;
            r_ridx   <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rid  <= axi_arid;
                r_rlen <= axi_arlen;
                r_ridx <= axi_araddr[MEM_ADDR_WIDTH+c_S-1 -: MEM_ADDR_WIDTH];
                r_rerr <= (axi_arburst != c_BURST_INCR);
                r_rcnt <= 8'd0;
            end else if (w_r_hs && !w_rbeat_last) begin
                r_ridx <= r_ridx + 1'b1;
                r_rcnt <= r_rcnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        axi_arready  = 1'b0;
        axi_rvalid   = 1'b0;
        axi_rresp    = c_RESP_OKAY;
        axi_rlast    = 1'b0;
        axi_rdata    = '0;
        w_mem_re     = 1'b0;
        case (r_rstate)
            RIDLE: begin
                axi_arready = 1'b1;
                if (axi_arvalid) begin
                    w_rstate_nxt = RFETCH;
                end
            end
            RFETCH: begin
                w_mem_re     = 1'b1;
                w_rstate_nxt = RDATA;
            end
            RDATA: begin
                // RAM output only changes in RFETCH, so the beat holds under backpressure.
                axi_rvalid = 1'b1;
                axi_rdata  = w_mem_q;
                axi_rresp  = r_rerr ? c_RESP_SLVERR : c_RESP_OKAY;
                axi_rlast  = w_rbeat_last;
                if (axi_rready) begin
                    w_rstate_nxt = w_rbeat_last ? RIDLE : RFETCH;
                end
            end
            default: w_rstate_nxt = RIDLE;
        endcase
    end

    assign axi_rid = r_rid;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    axi_bist_mem_dpram #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_dpram (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_widx),
        .i_wr_data (axi_wdata),
        .i_wr_strb (axi_wstrb),
        .i_rd_en   (w_mem_re),
        .i_rd_addr (r_ridx),
        .o_rd_data (w_mem_q)
    );

    // Size fields and out-of-range address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{axi_awsize, axi_arsize, axi_awaddr, axi_araddr};

endmodule

`default_nettype wire

// File: tb/tb_axi_bist_mem_responder.sv
// ============================================================================
// Module  : tb_axi_bist_mem_responder
// Brief   : Directed table-driven bench for axi_bist_mem_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_bist_mem_responder;

    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int SW  = DW / 8;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awid;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [7:0]    axi_bid;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arid;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [7:0]    axi_rid;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;

    axi_bist_mem_responder #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awaddr  (axi_awaddr),
        .axi_awid    (axi_awid),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arid    (axi_arid),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rid     (axi_rid),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rd_data_q [0:255];
    logic [1:0]    rd_resp_q [0:255];
    logic          rd_last_q [0:255];
    logic [7:0]    rd_id_q   [0:255];
    logic [7:0]    wr_bid;
    logic [1:0]    wr_bresp;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] seed;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [0:8];

    function automatic logic [DW-1:0] pat(input logic [31:0] seed, input int b);
        logic [31:0] w;
        w = seed + 32'(b);
        return {8{w}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=stuck expected=handshake", name);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_awready"}, DW'(axi_awready), DW'(1));
        check({tag, "_arready"}, DW'(axi_arready), DW'(1));
        check({tag, "_wready"},  DW'(axi_wready),  '0);
        check({tag, "_bvalid"},  DW'(axi_bvalid),  '0);
        check({tag, "_bid"},     DW'(axi_bid),     '0);
        check({tag, "_bresp"},   DW'(axi_bresp),   '0);
        check({tag, "_rvalid"},  DW'(axi_rvalid),  '0);
        check({tag, "_rdata"},   axi_rdata,        '0);
        check({tag, "_rid"},     DW'(axi_rid),     '0);
        check({tag, "_rresp"},   DW'(axi_rresp),   '0);
        check({tag, "_rlast"},   DW'(axi_rlast),   '0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] seed, input logic [SW-1:0] strb);
        int n;
        @(negedge clk);
        axi_awaddr = addr; axi_awid = id; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("aw_handshake");
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            axi_wdata = pat(seed, b); axi_wstrb = strb; axi_wlast = (b == int'(len)); axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) timeout("w_handshake");
            @(negedge clk);
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
        n = 0;
        while (!axi_bvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("b_handshake");
        wr_bid = axi_bid; wr_bresp = axi_bresp;
        @(negedge clk);
        axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                            input logic [1:0] burst);
        int n;
        @(negedge clk);
        axi_araddr = addr; axi_arid = id; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("ar_handshake");
        @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!axi_rvalid && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) timeout("r_handshake");
            rd_data_q[b] = axi_rdata; rd_resp_q[b] = axi_rresp;
            rd_last_q[b] = axi_rlast; rd_id_q[b] = axi_rid;
            @(negedge clk);
        end
        axi_rready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] cap_data;
        logic          cap_last;
        logic          stable;
        logic          seen_b;
        logic [DW-1:0] exp_word;
        int            n;

        vecs[0] = '{1'b1, 32'h0000_0040, 8'h11, 8'd3,   2'b01, 32'hA000_0000, 2'b00};
        vecs[1] = '{1'b0, 32'h0000_0040, 8'h22, 8'd3,   2'b01, 32'hA000_0000, 2'b00};
        vecs[2] = '{1'b1, 32'h0000_1000, 8'h33, 8'd0,   2'b01, 32'h1234_5678, 2'b00};
        vecs[3] = '{1'b0, 32'h0000_1000, 8'h44, 8'd0,   2'b01, 32'h1234_5678, 2'b00};
        vecs[4] = '{1'b0, 32'h0000_0040, 8'h55, 8'd1,   2'b10, 32'hA000_0000, 2'b10};
        vecs[5] = '{1'b1, 32'h0000_2000, 8'h66, 8'd7,   2'b01, 32'h0000_0005, 2'b00};
        vecs[6] = '{1'b0, 32'h0000_2020, 8'h77, 8'd6,   2'b01, 32'h0000_0006, 2'b00};
        vecs[7] = '{1'b1, 32'h0000_4000, 8'h88, 8'd255, 2'b01, 32'h0000_0100, 2'b00};
        vecs[8] = '{1'b0, 32'h0000_4000, 8'h99, 8'd255, 2'b01, 32'h0000_0100, 2'b00};

        rst = 1'b1;
        axi_awaddr = '0; axi_awid = '0; axi_awlen = '0; axi_awsize = 3'd5; axi_awburst = 2'b01;
        axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_araddr = '0; axi_arid = '0; axi_arlen = '0; axi_arsize = 3'd5;
        axi_arburst = 2'b01; axi_arvalid = 1'b0; axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_wr) begin
                axi_write(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].burst, vecs[v].seed, '1);
                check($sformatf("v%0d_bresp", v), DW'(wr_bresp), DW'(vecs[v].exp_resp));
                check($sformatf("v%0d_bid", v), DW'(wr_bid), DW'(vecs[v].id));
            end else begin
                axi_read(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].burst);
                for (int b = 0; b <= int'(vecs[v].len); b++) begin
                    check($sformatf("v%0d_b%0d_rdata", v, b), rd_data_q[b], pat(vecs[v].seed, b));
                    check($sformatf("v%0d_b%0d_rresp", v, b), DW'(rd_resp_q[b]), DW'(vecs[v].exp_resp));
                    check($sformatf("v%0d_b%0d_rid", v, b), DW'(rd_id_q[b]), DW'(vecs[v].id));
                    check($sformatf("v%0d_b%0d_rlast", v, b), DW'(rd_last_q[b]), DW'(b == int'(vecs[v].len)));
                end
            end
        end

        // Partial strobe over an all-ones word.
        axi_write(32'h0000_00A0, 8'h01, 8'd0, 2'b01, 32'hFFFF_FFFF, '1);
        axi_write(32'h0000_00A0, 8'h02, 8'd0, 2'b01, 32'h0000_0000, 32'h0000_000F);
        check("strb_bresp", DW'(wr_bresp), DW'(2'b00));
        axi_read(32'h0000_00A0, 8'h03, 8'd0, 2'b01);
        exp_word = {{(DW-32){1'b1}}, 32'h0000_0000};
        check("strb_rdata", rd_data_q[0], exp_word);

        // Non-INCR write is acknowledged with SLVERR and leaves memory alone.
        axi_write(32'h0000_0140, 8'h04, 8'd1, 2'b01, 32'h0000_0077, '1);
        axi_write(32'h0000_0140, 8'h05, 8'd1, 2'b10, 32'h0000_0099, '1);
        check("badburst_bresp", DW'(wr_bresp), DW'(2'b10));
        check("badburst_bid", DW'(wr_bid), DW'(8'h05));
        axi_read(32'h0000_0140, 8'h06, 8'd1, 2'b01);
        check("badburst_mem0", rd_data_q[0], pat(32'h77, 0));
        check("badburst_mem1", rd_data_q[1], pat(32'h77, 1));

        // Backpressure on beat 0, then the 2-cycle beat spacing.
        @(negedge clk);
        axi_araddr = 32'h40; axi_arid = 8'hAB; axi_arlen = 8'd1; axi_arburst = 2'b01; axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("stall_ar");
        @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b0;
        n = 0;
        while (!axi_rvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("stall_rvalid");
        cap_data = axi_rdata; cap_last = axi_rlast;
        check("stall_b0_rdata", cap_data, pat(32'hA000_0000, 0));
        check("stall_b0_rlast", DW'(cap_last), '0);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!axi_rvalid || axi_rdata !== cap_data || axi_rlast !== cap_last) stable = 1'b0;
        end
        check("stall_stable", DW'(stable), DW'(1));
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        check("stall_gap_rvalid", DW'(axi_rvalid), '0);
        @(negedge clk);
        check("stall_b1_rvalid", DW'(axi_rvalid), DW'(1));
        check("stall_b1_rdata", axi_rdata, pat(32'hA000_0000, 1));
        check("stall_b1_rlast", DW'(axi_rlast), DW'(1));
        check("stall_b1_rid", DW'(axi_rid), DW'(8'hAB));
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;

        // Burst from the top word wraps to word 0.
        axi_write(32'h0000_7FE0, 8'h07, 8'd1, 2'b01, 32'h0000_00C0, '1);
        check("wrap_bresp", DW'(wr_bresp), DW'(2'b00));
        axi_read(32'h0000_0000, 8'h08, 8'd0, 2'b01);
        check("wrap_word0", rd_data_q[0], pat(32'hC0, 1));
        axi_read(32'h0000_7FE0, 8'h09, 8'd1, 2'b01);
        check("wrap_rd_b0", rd_data_q[0], pat(32'hC0, 0));
        check("wrap_rd_b1", rd_data_q[1], pat(32'hC0, 1));

        // Reset in the middle of a 4-beat write.
        @(negedge clk);
        axi_awaddr = 32'h3000; axi_awid = 8'h0A; axi_awlen = 8'd3; axi_awburst = 2'b01; axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("rst_aw");
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            axi_wdata = pat(32'hD0, b); axi_wstrb = '1; axi_wlast = 1'b0; axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) timeout("rst_w");
            @(negedge clk);
        end
        axi_wdata = pat(32'hD0, 2);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        axi_wvalid = 1'b0;
        rst = 1'b0;
        axi_bready = 1'b1;
        seen_b = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (axi_bvalid) seen_b = 1'b1;
        end
        axi_bready = 1'b0;
        check("midrst_no_bvalid", DW'(seen_b), '0);
        axi_read(32'h0000_3000, 8'h0B, 8'd1, 2'b01);
        check("midrst_beat0", rd_data_q[0], pat(32'hD0, 0));
        check("midrst_beat1", rd_data_q[1], pat(32'hD0, 1));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_bist_mem_responder.md
Name: axi_bist_mem_responder

Overview:
- AXI4 slave memory model that answers the AXI master port of the BIST data-align block in place of the DDR controller.
- Supports on-chip BIST loopback and closed-loop simulation of the align path.
- Accepts INCR write and read bursts and stores data in an internal word array with byte strobes.
- Returns B and R responses with independent write and read engines; one outstanding transaction per direction.

Parameters:
AXI_ADDR_WIDTH, 32, byte address width
AXI_DATA_WIDTH, 256, data width in bits; legal values 32/64/128/256/512
MEM_ADDR_WIDTH, 10, log2 of memory depth in AXI words

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
axi_awaddr  in  AXI_ADDR_WIDTH  write byte address
axi_awid  in  8  write ID
axi_awlen  in  8  beats minus 1
axi_awsize  in  3  ignored; full-width beats assumed
axi_awburst  in  2  burst type; only 2'b01 is legal
axi_awvalid  in  1  AW valid
axi_awready  out  1  AW ready
axi_wdata  in  AXI_DATA_WIDTH  write data
axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
axi_wlast  in  1  last write beat
axi_wvalid  in  1  W valid
axi_wready  out  1  W ready
axi_bid  out  8  response ID
axi_bresp  out  2  write response
axi_bvalid  out  1  B valid
axi_bready  in  1  B ready
axi_araddr  in  AXI_ADDR_WIDTH  read byte address
axi_arid  in  8  read ID
axi_arlen  in  8  beats minus 1
axi_arsize  in  3  ignored
axi_arburst  in  2  burst type
axi_arvalid  in  1  AR valid
axi_arready  out  1  AR ready
axi_rdata  out  AXI_DATA_WIDTH  read data
axi_rid  out  8  read ID
axi_rresp  out  2  read response
axi_rlast  out  1  last read beat
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready

Behaviour:
- Reset (rst high, async): all outputs 0, except axi_awready=1 and axi_arready=1. Both FSMs go to IDLE. Memory contents are not reset.
- Word index = addr[MEM_ADDR_WIDTH+S-1:S], where S=log2(AXI_DATA_WIDTH/8). Index increments by 1 per beat and wraps modulo 2^MEM_ADDR_WIDTH.
- Write FSM, WIDLE:
  - awready=1, wready=0.
  - On AW handshake: latch id, len, index; err = (awburst!=2'b01); beat counter = 0; go to WDATA.
- Write FSM, WDATA:
  - awready=0, wready=1.
  - Each W handshake writes the bytes whose wstrb bit is set, unless err is set. Counter increments.
  - If wlast != (cnt==len), set err.
  - When cnt==len is accepted, go to WRESP.
  - W beats are not accepted in WIDLE, even if wvalid arrives first.
- Write FSM, WRESP:
  - bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00.
  - Outputs are held until bready; on handshake go to WIDLE.
  - Next AW is accepted the cycle after B completes.
- Read FSM, RIDLE:
  - arready=1.
  - On AR handshake: latch id, len, index; err = (arburst!=2'b01); go to RFETCH.
- Read FSM, RFETCH:
  - arready=0.
  - Registered memory read of the current index; go to RDATA next cycle.
- Read FSM, RDATA:
  - rvalid=1, rdata=read word, rid=latched id, rresp = err ? 2'b10 : 2'b00, rlast=(cnt==len).
  - All R outputs are held stable while rvalid=1 and rready=0.
  - On handshake: if last, go to RIDLE; else increment index and cnt, go to RFETCH.
  - Throughput is 1 beat per 2 cycles; AR-to-first-rvalid latency is 2 cycles.
  - When err is set, data is still read from memory, and rresp=SLVERR on every beat.
- Read and write engines run concurrently (dual-port array).
- Same-cycle read and write of the same word: read returns the old data (read-first).
- Reset mid-burst aborts the burst: partial writes already committed remain in memory, and no B/R is issued afterwards.
- len=0 is a single beat; len=255 is 256 beats with the counter 8 bits wide, no overflow.

Decomposition:
- Shared package: AXI burst/resp encodings (INCR=2'b01, OKAY=2'b00, SLVERR=2'b10), the S shift function, FSM state typedefs.
- Sub-module axi_bist_mem_dpram:
  - one write port with byte enables;
  - one read port with a registered output and read-first behaviour;
  - depth 2^MEM_ADDR_WIDTH.

Test Plan:
- Write awaddr=0x40, awlen=3, data D0..D3, wstrb all ones; then read araddr=0x40, arlen=3 (AXI_DATA_WIDTH=256) -> bresp=00, bid equals awid; rdata=D0..D3, rlast only on beat 3, rid equals arid.
- Write word 5 with all ones, then write with wstrb=0x0000_000F and data 0 -> read word 5 returns low 4 bytes 0x00 and the remaining bytes 0xFF.
- awburst=2'b10 with len=1 -> both W beats accepted, memory unchanged, bresp=2'b10.
- Hold rready=0 for 5 cycles on beat 0 of an arlen=1 read -> rvalid, rdata, rlast stable throughout; second beat appears 2 cycles after the handshake.
- Write burst starting at the last word with len=1 -> second beat lands in word 0; readback confirms the wrap.
- Assert rst during the W beat 2 of 4 -> all outputs return to reset values immediately; beats 0-1 are present in memory and no bvalid appears.
